branch_predict_unit: RTL and testbench

- Parametrised successor to the ID-stage branch resolution logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. IF looks it up; ID updates it when a branch resolves.
- ID compares the actual outcome against the prediction carried through IFID and drives a mispredict/redirect request to the hazard and jump unit.
- Contains performance counters and a static-not-taken fallback mode.

---
 rtl/bp_pkg.sv | 42 ++++
 rtl/bp_table.sv | 36 +++
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 tb/tb_branch_predict_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch prediction unit: counter encodings,
// the BTB entry layout and PC index/tag extraction.
package bp_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned TAG_MAX_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t CTR_ALLOC_BR = WT;
  localparam ctr_t CTR_RESET    = WNT;

  // Tag field is sized for the widest legal tag; unused upper bits stay zero.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic                 isJump;
    logic [PC_W-1:0]      target;
    ctr_t                 ctr;
  } btbEntry_t;

  function automatic logic [PC_W-1:0] pcIndex(input logic [PC_W-1:0] pc,
                                               input int unsigned     idxW);
    logic [PC_W-1:0] mask;
    mask = (PC_W'(1) << idxW) - PC_W'(1);
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [TAG_MAX_W-1:0] pcTag(input logic [PC_W-1:0] pc,
                                                 input int unsigned     idxW,
                                                 input int unsigned     tagW);
    logic [PC_W-1:0] mask;
    mask = (PC_W'(1) << tagW) - PC_W'(1);
    return TAG_MAX_W'((pc >> (idxW + 2)) & mask);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: combinational lookup read, ID-side read for
// read-modify-write training, one synchronous write port and reset clear.
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookupIdx,
  output btbEntry_t        lookupEntry,
  input  logic [IDX_W-1:0] updIdx,
  output btbEntry_t        updEntry,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  btbEntry_t        wrData
);

  btbEntry_t mem [ENTRIES];

  // Reset has priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem[i] <= '{valid: 1'b0, tag: '0, isJump: 1'b0, target: '0, ctr: CTR_RESET};
      end
    end else if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign lookupEntry = mem[lookupIdx];
  assign updEntry    = mem[updIdx];

endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage branch resolution with BTB-based dynamic prediction, mispredict
// redirect, table training and saturating performance counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bp_enable,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken,
  output logic [31:0]       if_pred_target,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic              id_kill,
  input  logic [31:0]       id_pc,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic              id_taken,
  input  logic [31:0]       id_target,
  input  logic              id_pred_taken,
  input  logic [31:0]       id_pred_target,
  output logic              mispredict,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]     lkIdx;
  logic [TAG_MAX_W-1:0] lkTag;
  logic [IDX_W-1:0]     upIdx;
  logic [TAG_MAX_W-1:0] upTag;
  btbEntry_t            lkEntry;
  btbEntry_t            upEntry;
  btbEntry_t            wrData;
  logic                 wrEn;
  logic                 lkHit;
  logic                 upHit;
  logic                 ev;
  logic                 isCtrl;
  logic                 actual;
  logic [31:0]          seqPc;
  ctr_t                 ctrNext;

  assign lkIdx = IDX_W'(pcIndex(if_pc, IDX_W));
  assign lkTag = pcTag(if_pc, IDX_W, TAG_W);
  assign upIdx = IDX_W'(pcIndex(id_pc, IDX_W));
  assign upTag = pcTag(id_pc, IDX_W, TAG_W);

  bp_table #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .lookupIdx  (lkIdx),
    .lookupEntry(lkEntry),
    .updIdx     (upIdx),
    .updEntry   (upEntry),
    .wrEn       (wrEn),
    .wrIdx      (upIdx),
    .wrData     (wrData)
  );

  // IF-side prediction from registered table state (no write-first bypass).
  assign lkHit          = lkEntry.valid && (lkEntry.tag == lkTag);
  assign if_pred_taken  = !reset && bp_enable && lkHit && (lkEntry.isJump || lkEntry.ctr[1]);
  assign if_pred_target = if_pred_taken ? lkEntry.target : '0;

  // ID-side resolution; the kernel bit of the fall-through PC never changes.
  assign ev          = id_valid && !id_stall && !id_kill && !reset;
  assign isCtrl      = id_is_branch || id_is_jump;
  assign actual      = isCtrl && id_taken;
  assign seqPc       = {id_pc[31], id_pc[30:0] + 31'd4};
  assign mispredict  = ev && ((actual != id_pred_taken) ||
                              (actual && (id_pred_target != id_target)));
  assign redirect_pc = !ev ? '0 : (actual ? id_target : seqPc);

  assign upHit = upEntry.valid && (upEntry.tag == upTag);

  always_comb begin
    ctrNext = upEntry.ctr;
    if (id_taken) begin
      if (upEntry.ctr != ST) ctrNext = ctr_t'(upEntry.ctr + 2'd1);
    end else begin
      if (upEntry.ctr != SNT) ctrNext = ctr_t'(upEntry.ctr - 2'd1);
    end
  end

  // Training write for the entry indexed by id_pc.
  always_comb begin
    wrEn   = 1'b0;
    wrData = upEntry;
    if (ev) begin
      if (id_is_jump) begin
        wrEn   = 1'b1;
        wrData = '{valid: 1'b1, tag: upTag, isJump: 1'b1, target: id_target, ctr: ST};
      end else if (id_is_branch) begin
        if (upHit) begin
          wrEn          = 1'b1;
          wrData.isJump = 1'b0;
          wrData.ctr    = ctrNext;
          if (id_taken) wrData.target = id_target;
        end else if (id_taken) begin
          wrEn   = 1'b1;
          wrData = '{valid: 1'b1, tag: upTag, isJump: 1'b0, target: id_target,
                     ctr: CTR_ALLOC_BR};
        end
      end else if (id_pred_taken) begin
        wrEn         = 1'b1;
        wrData.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ev) begin
      if (isCtrl && (stat_branches != '1)) stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized checks of branch_predict_unit against an
// array-based behavioural model of the BTB and resolution rules.
module tb_branch_predict_unit;

  localparam int unsigned ENTRIES  = 16;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned STAT_W   = 4;
  localparam int unsigned STAT_MAX = (1 << STAT_W) - 1;

  logic              clk;
  logic              reset;
  logic              bp_enable;
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic [31:0]       if_pred_target;
  logic              id_valid;
  logic              id_stall;
  logic              id_kill;
  logic [31:0]       id_pc;
  logic              id_is_branch;
  logic              id_is_jump;
  logic              id_taken;
  logic [31:0]       id_target;
  logic              id_pred_taken;
  logic [31:0]       id_pred_target;
  logic              mispredict;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  branch_predict_unit #(
    .ENTRIES(ENTRIES),
    .TAG_W  (TAG_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bp_enable       (bp_enable),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken),
    .if_pred_target  (if_pred_target),
    .id_valid        (id_valid),
    .id_stall        (id_stall),
    .id_kill         (id_kill),
    .id_pc           (id_pc),
    .id_is_branch    (id_is_branch),
    .id_is_jump      (id_is_jump),
    .id_taken        (id_taken),
    .id_target       (id_target),
    .id_pred_taken   (id_pred_taken),
    .id_pred_target  (id_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  // Reference model: one slot per BTB line, plus plain integer statistics.
  bit          mValid [ENTRIES];
  int unsigned mTag   [ENTRIES];
  bit          mJump  [ENTRIES];
  logic [31:0] mTgt   [ENTRIES];
  int          mCtr   [ENTRIES];
  int unsigned mBr;
  int unsigned mMis;
  bit          evM;
  bit          expMis;

  function automatic int unsigned mIdx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned mTagOf(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic bit mPredicts(input logic [31:0] pc);
    int unsigned i;
    i = mIdx(pc);
    return mValid[i] && (mTag[i] == mTagOf(pc)) && (mJump[i] || mCtr[i] >= 2);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = 0;
      mJump[i]  = 1'b0;
      mTgt[i]   = 32'h0;
      mCtr[i]   = 1;
    end
    mBr  = 0;
    mMis = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAsserts++;
    assert (got === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit en, input logic [31:0] ipc, input bit v, input bit st,
                       input bit kl, input logic [31:0] pc, input bit br, input bit jp,
                       input bit tk, input logic [31:0] tgt, input bit pt,
                       input logic [31:0] ptg);
    bp_enable      = en;
    if_pc          = ipc;
    id_valid       = v;
    id_stall       = st;
    id_kill        = kl;
    id_pc          = pc;
    id_is_branch   = br;
    id_is_jump     = jp;
    id_taken       = tk;
    id_target      = tgt;
    id_pred_taken  = pt;
    id_pred_target = ptg;
  endtask

  task automatic idle(input bit en, input logic [31:0] ipc);
    drive(en, ipc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Compare every output against the model for the currently driven inputs.
  task automatic settleCheck();
    bit          expPred;
    logic [31:0] expTgt;
    bit          act;
    logic [31:0] expRed;
    int unsigned i;
    #2;
    i       = mIdx(if_pc);
    expPred = !reset && bp_enable && mPredicts(if_pc);
    expTgt  = expPred ? mTgt[i] : 32'h0;
    evM     = id_valid && !id_stall && !id_kill && !reset;
    act     = (id_is_branch || id_is_jump) && id_taken;
    expMis  = evM && ((act != id_pred_taken) || (act && id_pred_target != id_target));
    if (!evM)     expRed = 32'h0;
    else if (act) expRed = id_target;
    else          expRed = (id_pc & 32'h8000_0000) | ((id_pc + 32'd4) & 32'h7FFF_FFFF);
    check("pred_taken", 32'(if_pred_taken), 32'(expPred));
    check("pred_target", if_pred_target, expTgt);
    check("mispredict", 32'(mispredict), 32'(expMis));
    check("redirect_pc", redirect_pc, expRed);
    check("stat_branches", 32'(stat_branches), mBr);
    check("stat_mispredicts", 32'(stat_mispredicts), mMis);
  endtask

  // Clock edge, then apply the training rules to the model.
  task automatic advance();
    int unsigned j;
    int unsigned t;
    @(posedge clk);
    if (reset) begin
      modelReset();
    end else if (evM) begin
      if ((id_is_branch || id_is_jump) && mBr < STAT_MAX) mBr++;
      if (expMis && mMis < STAT_MAX) mMis++;
      j = mIdx(id_pc);
      t = mTagOf(id_pc);
      if (id_is_jump) begin
        mValid[j] = 1'b1; mTag[j] = t; mJump[j] = 1'b1; mTgt[j] = id_target; mCtr[j] = 3;
      end else if (id_is_branch) begin
        if (mValid[j] && mTag[j] == t) begin
          mJump[j] = 1'b0;
          if (id_taken) begin
            mTgt[j] = id_target;
            mCtr[j] = (mCtr[j] == 3) ? 3 : mCtr[j] + 1;
          end else begin
            mCtr[j] = (mCtr[j] == 0) ? 0 : mCtr[j] - 1;
          end
        end else if (id_taken) begin
          mValid[j] = 1'b1; mTag[j] = t; mJump[j] = 1'b0; mTgt[j] = id_target; mCtr[j] = 2;
        end
      end else if (id_pred_taken) begin
        mValid[j] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step();
    settleCheck();
    advance();
  endtask

  function automatic logic [31:0] rndPc();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0:       base = 32'h0040_0000;
      1:       base = 32'h0040_0400;
      2:       base = 32'h8000_0000;
      default: base = 32'hFFFF_FF80;
    endcase
    return base + 32'(4 * $urandom_range(0, 31));
  endfunction

  initial begin
    bit          expP;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ptg;
    int          kind;
    bit          tk;
    bit          pt;

    modelReset();
    reset = 1'b1;
    idle(1'b1, 32'h0040_0000);
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Lookup after reset.
    idle(1'b1, 32'h0040_0000);
    settleCheck();
    check("rst_pred", 32'(if_pred_taken), 32'h0);
    check("rst_stats", 32'(stat_branches) | 32'(stat_mispredicts), 32'h0);
    advance();

    // First taken branch allocates and redirects.
    drive(1'b1, 32'h0040_0000, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b1,
          32'h0040_0040, 1'b0, 32'h0);
    settleCheck();
    check("alloc_mis", 32'(mispredict), 32'h1);
    check("alloc_redirect", redirect_pc, 32'h0040_0040);
    advance();
    idle(1'b1, 32'h0040_0010);
    settleCheck();
    check("alloc_pred", 32'(if_pred_taken), 32'h1);
    check("alloc_target", if_pred_target, 32'h0040_0040);
    advance();

    // Three not-taken resolutions walk the counter down to zero.
    for (int k = 0; k < 3; k++) begin
      expP = (k == 0);
      drive(1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0,
            32'h0040_0040, expP, expP ? 32'h0040_0040 : 32'h0);
      settleCheck();
      check("nt_walk_pred", 32'(if_pred_taken), 32'(expP));
      if (k == 0) begin
        check("nt_mis", 32'(mispredict), 32'h1);
        check("nt_redirect", redirect_pc, 32'h0040_0014);
      end
      advance();
    end

    // Fall-through PC keeps bit 31 and wraps the low 31 bits.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_FFFC, 1'b1, 1'b0, 1'b0,
          32'h1234_5678, 1'b1, 32'h1234_5678);
    settleCheck();
    check("kbit_redirect", redirect_pc, 32'h8001_0000);
    advance();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0,
          32'h1234_5678, 1'b1, 32'h1234_5678);
    settleCheck();
    check("wrap_redirect", redirect_pc, 32'h8000_0000);
    advance();

    // Jump entry, then an aliasing non-control instruction invalidates it.
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 1'b1, 1'b1,
          32'h0040_0100, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 32'h0040_0410, 1'b0, 1'b0, 1'b0,
          32'h0, 1'b1, 32'h0040_0100);
    settleCheck();
    check("alias_pre_pred", 32'(if_pred_taken), 32'h1);
    check("alias_mis", 32'(mispredict), 32'h1);
    check("alias_redirect", redirect_pc, 32'h0040_0414);
    advance();
    idle(1'b1, 32'h0040_0010);
    settleCheck();
    check("alias_cleared", 32'(if_pred_taken), 32'h0);
    advance();

    // Stall and kill suppress resolution, training and statistics.
    drive(1'b1, 32'h0040_0010, 1'b1, 1'b1, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b1,
          32'h0040_0200, 1'b0, 32'h0);
    settleCheck();
    check("stall_mis", 32'(mispredict), 32'h0);
    advance();
    drive(1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b1,
          32'h0040_0200, 1'b0, 32'h0);
    settleCheck();
    check("kill_mis", 32'(mispredict), 32'h0);
    advance();
    idle(1'b1, 32'h0040_0010);
    step();

    // Saturate both statistics.
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0040_0080 + 32'(4 * k), 1'b1, 1'b0, 1'b1,
            32'h0040_0800, 1'b0, 32'h0);
      step();
    end
    idle(1'b1, 32'h0);
    settleCheck();
    check("sat_mispredicts", 32'(stat_mispredicts), 32'hF);
    check("sat_branches", 32'(stat_branches), 32'hF);
    advance();

    // Training continues with prediction disabled.
    drive(1'b0, 32'h0040_0020, 1'b1, 1'b0, 1'b0, 32'h0040_0020, 1'b0, 1'b1, 1'b1,
          32'h0040_0300, 1'b0, 32'h0);
    step();
    idle(1'b0, 32'h0040_0020);
    settleCheck();
    check("dis_pred", 32'(if_pred_taken), 32'h0);
    advance();
    idle(1'b1, 32'h0040_0020);
    settleCheck();
    check("reen_pred", 32'(if_pred_taken), 32'h1);
    check("reen_target", if_pred_target, 32'h0040_0300);
    advance();

    // Reset coincident with an update: nothing is written.
    reset = 1'b1;
    drive(1'b1, 32'h0040_0030, 1'b1, 1'b0, 1'b0, 32'h0040_0030, 1'b0, 1'b1, 1'b1,
          32'h0040_0500, 1'b0, 32'h0);
    step();
    reset = 1'b0;
    idle(1'b1, 32'h0040_0030);
    settleCheck();
    check("rst_wins", 32'(if_pred_taken), 32'h0);
    advance();

    // Randomized traffic over a small, heavily aliasing PC pool.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      ipc   = rndPc();
      pc    = rndPc();
      tgt   = rndPc();
      kind  = $urandom_range(0, 3);
      tk    = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        pt  = mPredicts(pc);
        ptg = pt ? mTgt[mIdx(pc)] : 32'h0;
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = pt ? rndPc() : 32'h0;
      end
      drive(1'($urandom_range(0, 7) != 0), ipc, 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), pc,
            (kind == 0 || kind == 3), (kind == 1), tk, tgt, pt, ptg);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
